// File: rtl/march_config_controller.sv
// ============================================================================
// march_config_controller: staged run-time limits for fetch/commit width and
// IQ/ActiveList/LSQ occupancy, applied only after a settled pipeline drain.
// Revision: 1.0
// ============================================================================
`default_nettype none

module march_config_controller #(
  parameter int MAX_FETCH_WIDTH   = 2,
  parameter int MAX_COMMIT_WIDTH  = 2,
  parameter int MAX_IQ_ENTRY_NUM  = 16,
  parameter int MAX_AL_ENTRY_NUM  = 64,
  parameter int MAX_LSQ_ENTRY_NUM = 16,
  parameter int SETTLE_CYCLES     = 2,
  parameter int DRAIN_TIMEOUT     = 256,
  localparam int DW  = $clog2(MAX_AL_ENTRY_NUM + 1),
  localparam int FW  = $clog2(MAX_FETCH_WIDTH + 1),
  localparam int CW  = $clog2(MAX_COMMIT_WIDTH + 1),
  localparam int IW  = $clog2(MAX_IQ_ENTRY_NUM + 1),
  localparam int LW  = $clog2(MAX_LSQ_ENTRY_NUM + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfgWrite,
  input  logic [2:0]    cfgAddr,
  input  logic [DW-1:0] cfgData,
  input  logic          pipelineEmpty,
  output logic          cfgBusy,
  output logic          drainReq,
  output logic          cfgApplied,
  output logic          cfgError,
  output logic [FW-1:0] effFetchWidth,
  output logic [CW-1:0] effCommitWidth,
  output logic [IW-1:0] iqEntryLimit,
  output logic [DW-1:0] alEntryLimit,
  output logic [LW-1:0] lsqEntryLimit
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [2:0] ADDR_FETCH  = 3'd0;
  localparam logic [2:0] ADDR_COMMIT = 3'd1;
  localparam logic [2:0] ADDR_IQ     = 3'd2;
  localparam logic [2:0] ADDR_AL     = 3'd3;
  localparam logic [2:0] ADDR_LSQ    = 3'd4;
  localparam logic [2:0] ADDR_CMD    = 3'd7;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state, next_state;

  logic [FW-1:0] shadow_fetch;
  logic [CW-1:0] shadow_commit;
  logic [IW-1:0] shadow_iq;
  logic [DW-1:0] shadow_al;
  logic [LW-1:0] shadow_lsq;

  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] to_cnt;

  logic [31:0] data_wide;
  logic [31:0] limit_for_addr;
  logic        data_in_range;
  logic        shadow_wr;
  logic        do_apply;
  logic        err_set;

  assign data_wide = 32'(cfgData);

  always_comb begin
    limit_for_addr = 32'd0;
    case (cfgAddr)
      ADDR_FETCH:  limit_for_addr = 32'(MAX_FETCH_WIDTH);
      ADDR_COMMIT: limit_for_addr = 32'(MAX_COMMIT_WIDTH);
      ADDR_IQ:     limit_for_addr = 32'(MAX_IQ_ENTRY_NUM);
      ADDR_AL:     limit_for_addr = 32'(MAX_AL_ENTRY_NUM);
      ADDR_LSQ:    limit_for_addr = 32'(MAX_LSQ_ENTRY_NUM);
      default:     limit_for_addr = 32'd0;
    endcase
  end

  assign data_in_range = (data_wide >= 32'd1) && (data_wide <= limit_for_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Writes are only honoured in IDLE; DRAIN silently drops them.
  always_comb begin
    next_state = state;
    shadow_wr  = 1'b0;
    do_apply   = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (cfgWrite) begin
          if (cfgAddr == ADDR_CMD) begin
            // Commit width must cover rename width so recovery can drain.
            if (32'(shadow_commit) < 32'(shadow_fetch)) begin
              err_set = 1'b1;
            end else begin
              next_state = DRAIN;
            end
          end else if (cfgAddr <= ADDR_LSQ) begin
            if (data_in_range) begin
              shadow_wr = 1'b1;
            end else begin
              err_set = 1'b1;
            end
          end else begin
            err_set = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (pipelineEmpty && (settle_cnt == SW'(SETTLE_CYCLES - 1))) begin
          do_apply   = 1'b1;
          next_state = IDLE;
        end else if (to_cnt == TW'(DRAIN_TIMEOUT - 1)) begin
          err_set    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_fetch   <= FW'(MAX_FETCH_WIDTH);
      shadow_commit  <= CW'(MAX_COMMIT_WIDTH);
      shadow_iq      <= IW'(MAX_IQ_ENTRY_NUM);
      shadow_al      <= DW'(MAX_AL_ENTRY_NUM);
      shadow_lsq     <= LW'(MAX_LSQ_ENTRY_NUM);
      effFetchWidth  <= FW'(MAX_FETCH_WIDTH);
      effCommitWidth <= CW'(MAX_COMMIT_WIDTH);
      iqEntryLimit   <= IW'(MAX_IQ_ENTRY_NUM);
      alEntryLimit   <= DW'(MAX_AL_ENTRY_NUM);
      lsqEntryLimit  <= LW'(MAX_LSQ_ENTRY_NUM);
      settle_cnt     <= '0;
      to_cnt         <= '0;
      cfgApplied     <= 1'b0;
      cfgError       <= 1'b0;
    end else begin
      cfgApplied <= do_apply;
      cfgError   <= err_set;

      if (shadow_wr) begin
        case (cfgAddr)
          ADDR_FETCH:  shadow_fetch  <= FW'(cfgData);
          ADDR_COMMIT: shadow_commit <= CW'(cfgData);
          ADDR_IQ:     shadow_iq     <= IW'(cfgData);
          ADDR_AL:     shadow_al     <= DW'(cfgData);
          ADDR_LSQ:    shadow_lsq    <= LW'(cfgData);
          default:     ;
        endcase
      end

      if (do_apply) begin
        effFetchWidth  <= shadow_fetch;
        effCommitWidth <= shadow_commit;
        iqEntryLimit   <= shadow_iq;
        alEntryLimit   <= shadow_al;
        lsqEntryLimit  <= shadow_lsq;
      end

      // Holding the counters at zero in IDLE clears them on DRAIN entry.
      if (state == IDLE) begin
        settle_cnt <= '0;
        to_cnt     <= '0;
      end else begin
        settle_cnt <= pipelineEmpty ? settle_cnt + SW'(1) : '0;
        to_cnt     <= to_cnt + TW'(1);
      end
    end
  end

  assign cfgBusy  = (state == DRAIN);
  assign drainReq = cfgBusy;

endmodule

`default_nettype wire

// File: tb/tb_march_config_controller.sv
// ============================================================================
// tb_march_config_controller: directed self-checking bench for the controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_march_config_controller;

  logic       clk;
  logic       rst_n;
  logic       cfgWrite;
  logic [2:0] cfgAddr;
  logic [6:0] cfgData;
  logic       pipelineEmpty;
  logic       cfgBusy;
  logic       drainReq;
  logic       cfgApplied;
  logic       cfgError;
  logic [1:0] effFetchWidth;
  logic [1:0] effCommitWidth;
  logic [4:0] iqEntryLimit;
  logic [6:0] alEntryLimit;
  logic [4:0] lsqEntryLimit;

  int checks = 0;
  int errors = 0;

  march_config_controller #(
    .DRAIN_TIMEOUT(8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfgWrite      (cfgWrite),
    .cfgAddr       (cfgAddr),
    .cfgData       (cfgData),
    .pipelineEmpty (pipelineEmpty),
    .cfgBusy       (cfgBusy),
    .drainReq      (drainReq),
    .cfgApplied    (cfgApplied),
    .cfgError      (cfgError),
    .effFetchWidth (effFetchWidth),
    .effCommitWidth(effCommitWidth),
    .iqEntryLimit  (iqEntryLimit),
    .alEntryLimit  (alEntryLimit),
    .lsqEntryLimit (lsqEntryLimit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [6:0] d);
    cfgWrite = 1'b1;
    cfgAddr  = a;
    cfgData  = d;
    tick();
    cfgWrite = 1'b0;
  endtask

  task automatic check_limits(input string tag, input int f, input int c, input int iq,
                              input int al, input int lsq);
    check({tag, "_fetch"},  32'(effFetchWidth),  f);
    check({tag, "_commit"}, 32'(effCommitWidth), c);
    check({tag, "_iq"},     32'(iqEntryLimit),   iq);
    check({tag, "_al"},     32'(alEntryLimit),   al);
    check({tag, "_lsq"},    32'(lsqEntryLimit),  lsq);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cfgWrite = 1'b0;
    cfgAddr = 3'd0;
    cfgData = 7'd0;
    pipelineEmpty = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check_limits("rst", 2, 2, 16, 64, 16);
    check("rst_busy",    32'(cfgBusy),    0);
    check("rst_drain",   32'(drainReq),   0);
    check("rst_applied", 32'(cfgApplied), 0);
    check("rst_error",   32'(cfgError),   0);

    // Basic apply: fetch=1, AL=32, commit with pipelineEmpty high from cycle 1
    wr(3'd0, 7'd1);
    check("wr_fetch_err", 32'(cfgError), 0);
    wr(3'd3, 7'd32);
    check("wr_al_err", 32'(cfgError), 0);
    wr(3'd7, 7'd0);
    pipelineEmpty = 1'b1;
    check("c1_drain",   32'(drainReq),   1);
    check("c1_busy",    32'(cfgBusy),    1);
    check("c1_applied", 32'(cfgApplied), 0);
    tick();
    check("c2_drain", 32'(drainReq), 1);
    check("c2_fetch", 32'(effFetchWidth), 2);
    tick();
    check("c3_applied", 32'(cfgApplied), 1);
    check("c3_drain",   32'(drainReq),   0);
    check_limits("c3", 1, 2, 16, 32, 16);
    tick();
    check("c4_applied", 32'(cfgApplied), 0);
    pipelineEmpty = 1'b0;

    // Out-of-range and reserved writes
    wr(3'd3, 7'd65);
    check("al65_err", 32'(cfgError), 1);
    check("al65_al",  32'(alEntryLimit), 32);
    tick();
    check("err_clear", 32'(cfgError), 0);
    wr(3'd3, 7'd0);
    check("al0_err", 32'(cfgError), 1);
    wr(3'd0, 7'd3);
    check("fetch3_err", 32'(cfgError), 1);
    wr(3'd5, 7'd1);
    check("addr5_err", 32'(cfgError), 1);
    wr(3'd6, 7'd1);
    check("addr6_err", 32'(cfgError), 1);
    check("addr6_busy", 32'(cfgBusy), 0);

    // Commit narrower than fetch is rejected
    wr(3'd1, 7'd1);
    check("wr_commit_err", 32'(cfgError), 0);
    wr(3'd0, 7'd2);
    wr(3'd7, 7'd0);
    check("cmd_bad_err",  32'(cfgError), 1);
    check("cmd_bad_busy", 32'(cfgBusy),  0);
    tick();
    check("cmd_bad_busy2", 32'(cfgBusy), 0);
    check_limits("cmd_bad", 1, 2, 16, 32, 16);

    // Settle counter restart: pipelineEmpty 1,0,1,1; a DRAIN write is dropped
    wr(3'd0, 7'd1);
    wr(3'd4, 7'd8);
    wr(3'd7, 7'd0);
    pipelineEmpty = 1'b1;
    check("s1_busy", 32'(cfgBusy), 1);
    tick();
    pipelineEmpty = 1'b0;
    cfgWrite = 1'b1;
    cfgAddr  = 3'd2;
    cfgData  = 7'd4;
    tick();
    cfgWrite = 1'b0;
    pipelineEmpty = 1'b1;
    check("s3_busy", 32'(cfgBusy), 1);
    check("s3_err",  32'(cfgError), 0);
    tick();
    check("s4_busy",    32'(cfgBusy),    1);
    check("s4_applied", 32'(cfgApplied), 0);
    tick();
    check("s5_applied", 32'(cfgApplied), 1);
    check("s5_busy",    32'(cfgBusy),    0);
    check_limits("s5", 1, 1, 16, 32, 8);
    pipelineEmpty = 1'b0;

    // Drain timeout with DRAIN_TIMEOUT=8
    wr(3'd2, 7'd10);
    wr(3'd7, 7'd0);
    for (int i = 1; i <= 8; i++) begin
      if (i == 1 || i == 8) begin
        check("to_busy", 32'(cfgBusy),  1);
        check("to_err",  32'(cfgError), 0);
      end
      tick();
    end
    check("to9_err",  32'(cfgError),   1);
    check("to9_busy", 32'(cfgBusy),    0);
    check("to9_app",  32'(cfgApplied), 0);
    check_limits("to9", 1, 1, 16, 32, 8);
    tick();
    check("to10_err", 32'(cfgError), 0);

    // Reset mid-drain discards pending shadows (iq=10)
    wr(3'd7, 7'd0);
    tick();
    check("rd_busy", 32'(cfgBusy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rd_drain", 32'(drainReq), 0);
    check("rd_busy0", 32'(cfgBusy),  0);
    check_limits("rd", 2, 2, 16, 64, 16);
    tick();
    rst_n = 1'b1;
    tick();
    wr(3'd7, 7'd0);
    pipelineEmpty = 1'b1;
    tick();
    tick();
    check("post_rst_applied", 32'(cfgApplied), 1);
    check_limits("post_rst", 2, 2, 16, 64, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
